// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_pkg
//  Purpose  : Shared RV32 integer constants: datapath width, register count
//             and the funct3 encodings of the integer load instructions.
//  Revision : 1.0 - initial release
// ============================================================================
package rv32_pkg;

  localparam int XLEN           = 32;
  localparam int REG_COUNT      = 32;
  localparam int REG_ADDR_WIDTH = $clog2(REG_COUNT);

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
//  Module   : load_align
//  Purpose  : Combinational load formatter. Selects the byte or halfword
//             addressed by the low address bits of a raw memory word and
//             sign- or zero-extends it according to the load type.
//  Ports    : raw_word [XLEN-1:0]  word as returned by memory
//             funct3   [2:0]       load type
//             offset   [1:0]       address bits [1:0] (byte lane)
//             data_out [XLEN-1:0]  value to write to the register file
//  Revision : 1.0 - initial release
// ============================================================================
module load_align
  import rv32_pkg::*;
#(
  parameter int XLEN = rv32_pkg::XLEN
) (
  input  logic [XLEN-1:0] raw_word,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] data_out
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = raw_word[{offset, 3'b000} +: 8];
    // Halfword lane is picked by offset[1] only; offset[0] is ignored.
    w_half   = offset[1] ? raw_word[31:16] : raw_word[15:0];
    data_out = raw_word;
    case (funct3)
      LB:      data_out = {{(XLEN-8){w_byte[7]}}, w_byte};
      LH:      data_out = {{(XLEN-16){w_half[15]}}, w_half};
      LBU:     data_out = {{(XLEN-8){1'b0}}, w_byte};
      LHU:     data_out = {{(XLEN-16){1'b0}}, w_half};
      default: data_out = raw_word;
    endcase
  end

endmodule : load_align
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_writeback
//  Purpose  : Write-side front end of the integer register file. Arbitrates
//             load responses (priority) against ALU results, formats load
//             data, tracks outstanding load destinations in an in-order
//             queue and publishes a per-register pending mask for decode.
//  Ports    : clk, reset_n                  clock / async active-low reset
//             alu_valid/ready/rd/data        ALU result handshake
//             ld_issue_valid/ready/rd/funct3/offset  load issue handshake
//             ld_rsp_valid/ready/data        in-order memory response
//             wr_en/wr_addr/wr_data          registered register-file write
//             pending_mask                   bit i = load to xi outstanding
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_writeback
  import rv32_pkg::*;
#(
  parameter int XLEN              = rv32_pkg::XLEN,
  parameter int REG_FILE_DEPTH    = rv32_pkg::REG_COUNT,
  parameter int REG_FILE_ADDR_LEN = $clog2(REG_FILE_DEPTH),
  parameter int LD_QUEUE_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [REG_FILE_ADDR_LEN-1:0] alu_rd,
  input  logic [XLEN-1:0]              alu_data,
  input  logic                         ld_issue_valid,
  output logic                         ld_issue_ready,
  input  logic [REG_FILE_ADDR_LEN-1:0] ld_issue_rd,
  input  logic [2:0]                   ld_issue_funct3,
  input  logic [1:0]                   ld_issue_offset,
  input  logic                         ld_rsp_valid,
  output logic                         ld_rsp_ready,
  input  logic [XLEN-1:0]              ld_rsp_data,
  output logic                         wr_en,
  output logic [REG_FILE_ADDR_LEN-1:0] wr_addr,
  output logic [XLEN-1:0]              wr_data,
  output logic [REG_FILE_DEPTH-1:0]    pending_mask
);

  localparam int PTR_W = $clog2(LD_QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Load queue storage (no reset needed: validity is tracked by r_count)
  logic [REG_FILE_ADDR_LEN-1:0] r_q_rd     [LD_QUEUE_DEPTH];
  logic [2:0]                   r_q_funct3 [LD_QUEUE_DEPTH];
  logic [1:0]                   r_q_offset [LD_QUEUE_DEPTH];

  logic [PTR_W-1:0]             r_wr_ptr;
  logic [PTR_W-1:0]             r_rd_ptr;
  logic [CNT_W-1:0]             r_count;
  logic [REG_FILE_DEPTH-1:0]    r_pending;

  logic                         w_empty;
  logic                         w_full;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_alu_grant;
  logic [REG_FILE_ADDR_LEN-1:0] w_head_rd;
  logic [XLEN-1:0]              w_ld_data;
  logic [REG_FILE_DEPTH-1:0]    w_pending_next;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(LD_QUEUE_DEPTH));
  assign w_head_rd = r_q_rd[r_rd_ptr];

  // A second load to a register that is already pending is held off so the
  // pending bit always belongs to exactly one queue entry.
  assign ld_issue_ready = !w_full &&
                          !((ld_issue_rd != '0) && r_pending[ld_issue_rd]);
  assign ld_rsp_ready   = !w_empty;

  assign w_push      = ld_issue_valid && ld_issue_ready;
  assign w_pop       = ld_rsp_valid && !w_empty;
  assign alu_ready   = !w_pop;
  assign w_alu_grant = alu_valid && alu_ready;

  assign pending_mask = r_pending;

  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .raw_word (ld_rsp_data),
    .funct3   (r_q_funct3[r_rd_ptr]),
    .offset   (r_q_offset[r_rd_ptr]),
    .data_out (w_ld_data)
  );

  // Clear for the retiring head, set for the new issue. They never target
  // the same register because issue to a pending rd is refused.
  always_comb begin
    w_pending_next = r_pending;
    if (w_pop && (w_head_rd != '0)) begin
      w_pending_next[w_head_rd] = 1'b0;
    end
    if (w_push && (ld_issue_rd != '0)) begin
      w_pending_next[ld_issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wr_ptr]     <= ld_issue_rd;
      r_q_funct3[r_wr_ptr] <= ld_issue_funct3;
      r_q_offset[r_wr_ptr] <= ld_issue_offset;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered write port; address/data hold when nothing is granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (w_pop) begin
      wr_en   <= (w_head_rd != '0);
      wr_addr <= w_head_rd;
      wr_data <= w_ld_data;
    end else if (w_alu_grant) begin
      wr_en   <= (alu_rd != '0);
      wr_addr <= alu_rd;
      wr_data <= alu_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  // Memory must not return data with no load outstanding.
  a_rsp_with_empty_queue : assert property (
    @(posedge clk) disable iff (!reset_n) ld_rsp_valid |-> !w_empty);

  // Decode must stall an ALU op whose destination still awaits a load.
  a_alu_to_pending_rd : assert property (
    @(posedge clk) disable iff (!reset_n)
    (w_alu_grant && (alu_rd != '0)) |-> !r_pending[alu_rd]);
`endif

endmodule : regfile_writeback
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_writeback
//  Purpose  : Directed scoreboard bench for regfile_writeback. Stimulus
//             pushes each expected register-file write into a queue; a
//             negedge monitor pops and compares every wr_en pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue_valid;
  logic        ld_issue_ready;
  logic [4:0]  ld_issue_rd;
  logic [2:0]  ld_issue_funct3;
  logic [1:0]  ld_issue_offset;
  logic        ld_rsp_valid;
  logic        ld_rsp_ready;
  logic [31:0] ld_rsp_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pending_mask;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  regfile_writeback dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .ld_issue_valid  (ld_issue_valid),
    .ld_issue_ready  (ld_issue_ready),
    .ld_issue_rd     (ld_issue_rd),
    .ld_issue_funct3 (ld_issue_funct3),
    .ld_issue_offset (ld_issue_offset),
    .ld_rsp_valid    (ld_rsp_valid),
    .ld_rsp_ready    (ld_rsp_ready),
    .ld_rsp_data     (ld_rsp_data),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .pending_mask    (pending_mask)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d data %h expected none",
                 wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e.addr));
        check("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  task automatic issue(input logic [4:0] rd, input logic [2:0] f3,
                       input logic [1:0] off, input logic exp_ok);
    ld_issue_valid  = 1'b1;
    ld_issue_rd     = rd;
    ld_issue_funct3 = f3;
    ld_issue_offset = off;
    #1;
    check("ld_issue_ready", 64'(ld_issue_ready), 64'(exp_ok));
    @(posedge clk);
    #1;
    ld_issue_valid = 1'b0;
    if (exp_ok && rd != 5'd0)
      check("pending_set", 64'(pending_mask[rd]), 64'd1);
  endtask

  task automatic respond(input logic [31:0] raw, input logic [4:0] rd,
                         input logic [31:0] exp_data);
    ld_rsp_valid = 1'b1;
    ld_rsp_data  = raw;
    #1;
    check("ld_rsp_ready", 64'(ld_rsp_ready), 64'd1);
    if (rd != 5'd0) exp_q.push_back('{addr: rd, data: exp_data});
    @(posedge clk);
    #1;
    ld_rsp_valid = 1'b0;
    check("ld_wr_en", 64'(wr_en), 64'(rd != 5'd0));
    if (rd != 5'd0)
      check("pending_clear", 64'(pending_mask[rd]), 64'd0);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] data);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = data;
    #1;
    check("alu_ready", 64'(alu_ready), 64'd1);
    if (rd != 5'd0) exp_q.push_back('{addr: rd, data: data});
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    check("alu_wr_en", 64'(wr_en), 64'(rd != 5'd0));
  endtask

  initial begin
    reset_n         = 1'b0;
    alu_valid       = 1'b0;
    alu_rd          = '0;
    alu_data        = '0;
    ld_issue_valid  = 1'b0;
    ld_issue_rd     = '0;
    ld_issue_funct3 = '0;
    ld_issue_offset = '0;
    ld_rsp_valid    = 1'b0;
    ld_rsp_data     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;

    // Reset / idle state
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_pending", 64'(pending_mask), 64'd0);
    check("rst_issue_ready", 64'(ld_issue_ready), 64'd1);
    check("rst_rsp_ready", 64'(ld_rsp_ready), 64'd0);
    @(posedge clk);
    #1;

    // ALU writes, including x0 which must not produce a write
    alu(5'd5, 32'hDEADBEEF);
    alu(5'd0, 32'h12345678);

    // Load formatting
    issue(5'd3, 3'b000, 2'd2, 1'b1);
    respond(32'h0080_0000, 5'd3, 32'hFFFF_FF80);
    issue(5'd7, 3'b101, 2'd2, 1'b1);
    respond(32'h8001_1234, 5'd7, 32'h0000_8001);
    issue(5'd9, 3'b000, 2'd0, 1'b1);
    respond(32'h0000_0090, 5'd9, 32'hFFFF_FF90);
    issue(5'd11, 3'b001, 2'd2, 1'b1);
    respond(32'h8001_1234, 5'd11, 32'hFFFF_8001);
    issue(5'd12, 3'b100, 2'd3, 1'b1);
    respond(32'hAB00_0000, 5'd12, 32'h0000_00AB);
    issue(5'd13, 3'b011, 2'd1, 1'b1);
    respond(32'h5566_7788, 5'd13, 32'h5566_7788);

    // Load to x0: never pending, slot still consumed, no write
    issue(5'd0, 3'b010, 2'd0, 1'b1);
    check("x0_not_pending", 64'(pending_mask), 64'd0);
    respond(32'hFFFF_FFFF, 5'd0, 32'h0);
    check("x0_queue_empty", 64'(ld_rsp_ready), 64'd0);

    // Fill the queue, 5th refused
    for (int k = 1; k <= 4; k++) issue(5'(k), 3'b010, 2'd0, 1'b1);
    issue(5'd5, 3'b010, 2'd0, 1'b0);
    check("full_mask", 64'(pending_mask), 64'h0000_001E);

    // Drain with ALU competing; issue attempted while full and popping
    alu_valid = 1'b1;
    alu_rd    = 5'd10;
    alu_data  = 32'h0BAD_F00D;
    for (int k = 1; k <= 4; k++) begin
      ld_rsp_valid = 1'b1;
      ld_rsp_data  = 32'h0101_0101 * k;
      if (k == 1) begin
        ld_issue_valid  = 1'b1;
        ld_issue_rd     = 5'd5;
        ld_issue_funct3 = 3'b010;
        ld_issue_offset = 2'd0;
      end
      #1;
      check("alu_blocked", 64'(alu_ready), 64'd0);
      if (k == 1) check("issue_full_pop", 64'(ld_issue_ready), 64'd0);
      exp_q.push_back('{addr: 5'(k), data: 32'h0101_0101 * k});
      @(posedge clk);
      #1;
      ld_issue_valid = 1'b0;
    end
    ld_rsp_valid = 1'b0;
    #1;
    check("alu_free", 64'(alu_ready), 64'd1);
    check("drained_rsp_ready", 64'(ld_rsp_ready), 64'd0);
    exp_q.push_back('{addr: 5'd10, data: 32'h0BAD_F00D});
    @(posedge clk);
    #1;
    alu_valid = 1'b0;

    // Same-rd reissue
    issue(5'd6, 3'b010, 2'd0, 1'b1);
    issue(5'd6, 3'b010, 2'd0, 1'b0);
    respond(32'h0000_CAFE, 5'd6, 32'h0000_CAFE);
    issue(5'd6, 3'b100, 2'd1, 1'b1);
    check("reissue_mask", 64'(pending_mask), 64'h0000_0040);
    respond(32'h0000_CAFE, 5'd6, 32'h0000_00CA);

    // Let the monitor catch the last write
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("final_pending", 64'(pending_mask), 64'd0);
    check("final_wr_en", 64'(wr_en), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_writeback
`default_nettype wire
